// File: rtl/fir_output_fifo.sv
// ============================================================================
// Module   : fir_output_fifo
// Purpose  : Elastic buffer from a non-stallable FIR output to an Avalon-ST
//            source, carrying packet markers and keeping sticky drop stats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_output_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sink_valid,
    input  logic [DATA_W-1:0]          sink_data,
    input  logic                       sink_startofpacket,
    input  logic                       sink_endofpacket,
    input  logic                       source_ready,
    output logic                       source_valid,
    output logic [DATA_W-1:0]          source_data,
    output logic                       source_startofpacket,
    output logic                       source_endofpacket,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    input  logic                       clear_stats,
    input  logic                       flush
);

    localparam int              C_AW    = $clog2(DEPTH);
    localparam int              C_LW    = C_AW + 1;
    localparam int              C_EW    = DATA_W + 2;
    localparam logic [C_LW-1:0] C_DEPTH = C_LW'(DEPTH);

    logic [C_EW-1:0] mem_q [DEPTH];
    logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_LW-1:0] level_q, level_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_count_q, drop_count_d;

    logic            full_w;
    logic            pop_w;
    logic            push_w;
    logic            drop_w;
    logic [C_EW-1:0] head_w;

    assign full_w = (level_q == C_DEPTH);
    assign pop_w  = source_valid && source_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push_w = sink_valid && !flush && (!full_w || pop_w);
    assign drop_w = sink_valid && !flush && full_w && !pop_w;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + C_AW'(1);
            end
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + C_AW'(1);
            end
            if (push_w && !pop_w) begin
                level_d = level_q + C_LW'(1);
            end else if (pop_w && !push_w) begin
                level_d = level_q - C_LW'(1);
            end
        end

        // Clearing the statistics outranks a drop in the same cycle.
        if (clear_stats) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop_w) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_w && !rst) begin
            mem_q[wr_ptr_q] <= {sink_startofpacket, sink_endofpacket, sink_data};
        end
    end

    assign head_w               = mem_q[rd_ptr_q];
    assign source_valid         = (level_q != '0);
    assign source_data          = source_valid ? head_w[DATA_W-1:0] : '0;
    assign source_endofpacket   = source_valid && head_w[DATA_W];
    assign source_startofpacket = source_valid && head_w[DATA_W+1];
    assign level                = level_q;
    assign overflow             = overflow_q;
    assign drop_count           = drop_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_output_fifo.sv
// ============================================================================
// Module   : tb_fir_output_fifo
// Purpose  : Scoreboard bench for fir_output_fifo with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_output_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sink_valid = 1'b0;
    logic [DATA_W-1:0] sink_data = '0;
    logic              sink_sop = 1'b0;
    logic              sink_eop = 1'b0;
    logic              source_ready = 1'b0;
    logic              source_valid;
    logic [DATA_W-1:0] source_data;
    logic              source_sop;
    logic              source_eop;
    logic [$clog2(DEPTH):0] level;
    logic              overflow;
    logic [15:0]       drop_count;
    logic              clear_stats = 1'b0;
    logic              flush = 1'b0;

    fir_output_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .sink_valid           (sink_valid),
        .sink_data            (sink_data),
        .sink_startofpacket   (sink_sop),
        .sink_endofpacket     (sink_eop),
        .source_ready         (source_ready),
        .source_valid         (source_valid),
        .source_data          (source_data),
        .source_startofpacket (source_sop),
        .source_endofpacket   (source_eop),
        .level                (level),
        .overflow             (overflow),
        .drop_count           (drop_count),
        .clear_stats          (clear_stats),
        .flush                (flush)
    );

    always #5 clk = ~clk;

    // Reference model: the queue is the FIFO contents in output order.
    entry_t sb[$];
    int     m_drops    = 0;
    bit     m_overflow = 1'b0;
    bit     started    = 1'b0;
    int     n_cmp      = 0;
    int     n_err      = 0;

    always @(posedge clk) begin
        bit full_before;
        bit pop;
        full_before = (sb.size() == DEPTH);
        pop         = (sb.size() != 0) && source_ready;
        started     = 1'b1;
        if (rst) begin
            sb.delete();
            m_drops    = 0;
            m_overflow = 1'b0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (flush) begin
                sb.delete();
            end else if (sink_valid) begin
                if (!full_before || pop) begin
                    sb.push_back('{sop: sink_sop, eop: sink_eop, data: sink_data});
                end else if (!clear_stats) begin
                    m_overflow = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (clear_stats) begin
                m_drops    = 0;
                m_overflow = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented head and status against the model.
    always @(negedge clk) begin
        if (started) begin
            check("level", int'(level), sb.size());
            check("valid", int'(source_valid), int'(sb.size() != 0));
            check("overflow", int'(overflow), int'(m_overflow));
            check("drop_count", int'(drop_count), m_drops);
            if (sb.size() != 0) begin
                check("data", int'(source_data), int'(sb[0].data));
                check("sop", int'(source_sop), int'(sb[0].sop));
                check("eop", int'(source_eop), int'(sb[0].eop));
            end else begin
                check("data_idle", int'(source_data), 0);
                check("sop_idle", int'(source_sop), 0);
                check("eop_idle", int'(source_eop), 0);
            end
        end
    end

    task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit s,
                       input bit e, input bit r, input bit f, input bit c);
        sink_valid   = v;
        sink_data    = d;
        sink_sop     = s;
        sink_eop     = e;
        source_ready = r;
        flush        = f;
        clear_stats  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(1'b0, DATA_W'($urandom), 1'b0, 1'b0, r, 1'b0, 1'b0);
    endtask

    initial begin
        int max_level;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2, 1'b1);

        // Pass-through with ready held high
        max_level = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, DATA_W'(i), i == 1, i == 8, 1'b1, 1'b0, 1'b0);
            if (int'(level) > max_level) max_level = int'(level);
        end
        idle(3, 1'b1);
        check("passthru_max_level", max_level, 1);

        // Fill past capacity then drain
        for (int i = 0; i < 20; i++)
            cyc(1'b1, DATA_W'(16'h0100 + i), i == 0, i == 19, 1'b0, 1'b0, 1'b0);
        check("fill_level", int'(level), 16);
        check("fill_drops", int'(drop_count), 4);
        idle(20, 1'b1);

        // Full with a simultaneous push and pop
        for (int i = 0; i < 16; i++)
            cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("full_pop_level", int'(level), 16);
        check("full_pop_drops", int'(drop_count), 0);
        idle(20, 1'b1);

        // Backpressure with ready toggling every other cycle
        for (int i = 0; i < 3; i++)
            cyc(1'b1, DATA_W'(16'hA000 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) idle(1, i[1]);

        // Flush versus clear
        for (int i = 0; i < 18; i++)
            cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(11, 1'b1);
        idle(1, 1'b0);
        check("pre_flush_level", int'(level), 5);
        cyc(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("flush_level", int'(level), 0);
        check("flush_drops", int'(drop_count), 2);
        for (int i = 0; i < 16; i++)
            cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clear_overflow", int'(overflow), 0);
        check("clear_drops", int'(drop_count), 0);
        idle(20, 1'b1);

        // Randomized traffic with occasional flush, clear and reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            cyc($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 7) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 79) == 0, $urandom_range(0, 79) == 0);
        end
        rst = 1'b0;
        idle(20, 1'b1);

        // Saturate the drop counter, then reset mid-burst
        for (int i = 0; i < 65540 + DEPTH; i++)
            cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_drops", int'(drop_count), 16'hFFFF);
        rst = 1'b1;
        cyc(1'b1, 16'hCAFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_level", int'(level), 0);
        check("rst_valid", int'(source_valid), 0);
        check("rst_drops", int'(drop_count), 0);
        check("rst_overflow", int'(overflow), 0);
        idle(4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
